// File: rtl/seq_pkg.sv
// seq_pkg: state encodings and defaults shared by the serializer and the sequence detectors.
package seq_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam int SEQ_WIDTH_DEFAULT = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_GAP   = S_GAP
    } ser_state_e;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out register; load keeps d minus its first bit, which the caller issues directly.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);
    logic [WIDTH-1:0] sr_q, sr_d;
    always_comb begin
        sr_d = load  ? ((MSB_FIRST != 0) ? d << 1 : d >> 1) :
               shift ? ((MSB_FIRST != 0) ? sr_q << 1 : sr_q >> 1) : sr_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else      sr_q <= sr_d;
    end
    assign q_bit = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: valid/ready word loader that shifts WIDTH bits out on x, one per clock, with an optional idle gap.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = SEQ_WIDTH_DEFAULT,
    parameter int   MSB_FIRST = 1,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    ser_state_e state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic x_q, x_d, x_valid_q, x_valid_d, done_q, done_d;
    logic last, hs, first_bit, q_bit, gap_last;
    assign last       = (state_q == ST_SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
    assign load_ready = (state_q == ST_IDLE) || (last && GAP == 0);
    assign hs         = load_valid && load_ready;
    assign first_bit  = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
    piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (hs),
        .shift ((state_q == ST_SHIFT) && !last),
        .d     (load_data),
        .q_bit (q_bit)
    );
    if (GAP > 0) begin : g_gap
        localparam int GW = $clog2(GAP + 1);
        logic [GW-1:0] gap_cnt_q, gap_cnt_d;
        assign gap_last = gap_cnt_q == GW'(GAP - 1);
        always_comb gap_cnt_d = (state_q == ST_GAP && !gap_last) ? gap_cnt_q + 1'b1 : '0;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) gap_cnt_q <= '0;
            else      gap_cnt_q <= gap_cnt_d;
        end
    end else begin : g_nogap
        assign gap_last = 1'b1;
    end
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (!last)        bit_cnt_d = bit_cnt_q + 1'b1;
                else if (GAP > 0) state_d   = ST_GAP;
                else if (hs)      bit_cnt_d = '0;
                else              state_d   = ST_IDLE;
            end
            ST_GAP:  state_d = gap_last ? ST_IDLE : ST_GAP;
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered, so they are computed one cycle ahead
        x_d       = hs ? first_bit : ((state_q == ST_SHIFT) && !last) ? q_bit : IDLE_BIT;
        x_valid_d = hs || ((state_q == ST_SHIFT) && !last);
        done_d    = (state_q == ST_SHIFT) && (bit_cnt_q == CW'(WIDTH - 2));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;
    assign busy    = state_q != ST_IDLE;
endmodule
